// File: rtl/xor_shared_arbiter.sv
// Round-robin arbiter that shares one W-bit XOR datapath between NREQ requesters.
// One grant at a time; the registered result is held until the consumer accepts it.
module xor_shared_arbiter #(
  parameter  int NREQ = 4,
  parameter  int W    = 6,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_x,
  input  logic [NREQ*W-1:0]   req_y,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [W-1:0]        rsp_z,
  input  logic                rsp_ready
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_z_q, rsp_z_d;

  logic           any_hi, any_lo, found;
  logic [IDW-1:0] hi_idx, lo_idx, gnt;
  logic [W-1:0]   sel_x, sel_y;

  // Lowest request at/above rr_q wins; otherwise wrap to the lowest request overall.
  always_comb begin
    any_hi = 1'b0;
    any_lo = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_lo = 1'b1;
        lo_idx = IDW'(i);
        if (IDW'(i) >= rr_q) begin
          any_hi = 1'b1;
          hi_idx = IDW'(i);
        end
      end
    end
    found = any_hi | any_lo;
    gnt   = any_hi ? hi_idx : lo_idx;
  end

  // Operand mux feeding the single shared XOR.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt) begin
        sel_x = req_x[i*W +: W];
        sel_y = req_y[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_z_d     = rsp_z_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          for (int i = 0; i < NREQ; i++) req_ready[i] = (IDW'(i) == gnt);
          rsp_z_d     = sel_x ^ sel_y;
          rsp_id_d    = gnt;
          rsp_valid_d = 1'b1;
          rr_d        = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_z_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_z_q     <= rsp_z_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;

endmodule

// File: tb/tb_xor_shared_arbiter.sv
// Bench for xor_shared_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level arbitration model.
module tb_xor_shared_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 6;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_x, req_y;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [W-1:0]        rsp_z;
  logic                rsp_ready;

  xor_shared_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_z(rsp_z), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // reference model state
  int m_rr;
  bit m_vld;
  int m_id;
  int m_z;

  logic [NREQ-1:0] obs_rdy;
  logic            obs_vld;
  logic [IDW-1:0]  obs_id;
  logic [W-1:0]    obs_z;
  int              last_gnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_rr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  // One clock: check outputs against the model at negedge, then advance the model.
  task automatic cyc();
    int g;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    g = pick();
    exp_rdy = (rst || m_vld || g < 0) ? '0 : NREQ'(1 << g);
    obs_rdy = req_ready; obs_vld = rsp_valid; obs_id = rsp_id; obs_z = rsp_z;
    chk("req_ready", 32'(obs_rdy), 32'(exp_rdy));
    chk("rsp_valid", 32'(obs_vld), 32'(m_vld));
    chk("rsp_id", 32'(obs_id), m_id);
    chk("rsp_z", 32'(obs_z), m_z);
    last_gnt = (exp_rdy != 0) ? g : -1;
    @(posedge clk);
    if (rst) begin
      m_rr = 0; m_vld = 0; m_id = 0; m_z = 0;
    end else if (!m_vld && g >= 0) begin
      m_z   = int'(req_x[g*W +: W] ^ req_y[g*W +: W]);
      m_id  = g;
      m_vld = 1;
      m_rr  = (g + 1) % NREQ;
    end else if (m_vld && rsp_ready) begin
      m_vld = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  logic            pend [NREQ];
  logic [W-1:0]    px   [NREQ];
  logic [W-1:0]    py   [NREQ];

  initial begin
    rst = 1'b1; req_valid = '1; req_x = '0; req_y = '0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    m_rr = 0; m_vld = 0; m_id = 0; m_z = 0; last_gnt = -1;

    // 1: reset held with all requests up
    cyc(); cyc();
    chk("t1_rdy", 32'(obs_rdy), 0);
    chk("t1_vld", 32'(obs_vld), 0);
    chk("t1_id", 32'(obs_id), 0);
    chk("t1_z", 32'(obs_z), 0);
    rst = 1'b0;

    // 2: single request from requester 2
    req_valid = 4'b0100; rsp_ready = 1'b1;
    req_x = {4{6'b101010}}; req_y = {4{6'b110011}};
    cyc();
    chk("t2_rdy", 32'(obs_rdy), 32'b0100);
    req_valid = '0;
    cyc();
    chk("t2_vld", 32'(obs_vld), 1);
    chk("t2_id", 32'(obs_id), 2);
    chk("t2_z", 32'(obs_z), 32'b011001);

    // 3: all requesting, grants rotate every other cycle
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*W +: W] = W'($urandom); req_y[i*W +: W] = W'($urandom);
    end
    req_valid = '1; rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk("t3_gnt", 32'(obs_rdy), (c % 2 == 0) ? (1 << ((c / 2) % NREQ)) : 0);
    end

    // 4: backpressure holds the response and blocks new grants
    do_reset();
    req_valid = 4'b0001; rsp_ready = 1'b0;
    cyc();
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("t4_rdy", 32'(obs_rdy), 0);
      chk("t4_vld", 32'(obs_vld), 1);
      chk("t4_id", 32'(obs_id), 0);
    end
    rsp_ready = 1'b1;
    cyc();
    chk("t4_hs_rdy", 32'(obs_rdy), 0);
    cyc();
    chk("t4_next", 32'(obs_rdy), 32'b0010);

    // 5: pointer at 3, only requester 1 -> wrap to 1, then pointer 2
    do_reset();
    req_valid = 4'b0100; rsp_ready = 1'b1;
    cyc();
    req_valid = '0;
    cyc();
    req_valid = 4'b0010;
    cyc();
    chk("t5_wrap", 32'(obs_rdy), 32'b0010);
    req_valid = '1;
    cyc();
    cyc();
    chk("t5_ptr", 32'(obs_rdy), 32'b0100);

    // 6: reset while a response is pending
    rsp_ready = 1'b0;
    cyc();
    chk("t6_pend", 32'(obs_vld), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("t6_vld", 32'(obs_vld), 0);
    chk("t6_rdy", 32'(obs_rdy), 32'b0001);

    // random traffic obeying the requester hold rule, with withdrawals and resets
    for (int i = 0; i < NREQ; i++) begin pend[i] = 0; px[i] = '0; py[i] = '0; end
    rsp_ready = 1'b1; last_gnt = -1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_gnt == i) pend[i] = 0;
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[i] = 1; px[i] = W'($urandom); py[i] = W'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 0;
        end
        req_valid[i]    = pend[i];
        req_x[i*W +: W] = px[i];
        req_y[i*W +: W] = py[i];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      cyc();
      if (rst) for (int i = 0; i < NREQ; i++) pend[i] = 0;
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
